disp_out_pipe: RTL and testbench



---
 rtl/disp_out_pipe.sv | 256 +++++++++++++++++++++++++
 tb/tb_disp_out_pipe.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_out_pipe.sv
// -----------------------------------------------------------------------------
// disp_out_pipe
//
// Display output stage between a pixel/pattern generator and the board video
// outputs. Each input cycle is processed in one registered stage:
//   * output mode selection (pass / greyscale / colour bars / blank), where a
//     mode change is only accepted on the in_frame cycle so it always lands on
//     a frame boundary,
//   * blanking of colour outside the active area (in_de = 0),
//   * BPC -> BPC_BOARD colour expansion by MSB-first bit replication.
// Stages 2..PIPE are plain delay, so every out_* signal is the matching in_*
// signal (processed) exactly PIPE cycles later. A free-running frame counter
// and the active mode are reported directly, without pipelining.
//
// Ports
//   clk                         pixel clock
//   rst_n                       asynchronous active-low reset
//   in_x, in_y      [CORDW]     signed display position
//   in_hsync/vsync/de/frame     timing from the display controller
//   in_r/g/b        [BPC]       pixel colour
//   mode            [2]         requested mode: 0 pass, 1 grey, 2 bars, 3 blank
//   out_x, out_y    [CORDW]     delayed position
//   out_hsync/vsync/de/frame    delayed timing
//   out_r/g/b       [BPC_BOARD] expanded colour
//   mode_active     [2]         mode currently applied
//   frame_count     [16]        in_frame pulses seen since reset (wraps)
// -----------------------------------------------------------------------------
module disp_out_pipe #(
  parameter int BPC       = 5,
  parameter int BPC_BOARD = 8,
  parameter int CORDW     = 16,
  parameter int PIPE      = 2,
  parameter int H_RES     = 640
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [CORDW-1:0] in_x,
  input  logic signed [CORDW-1:0] in_y,
  input  logic                    in_hsync,
  input  logic                    in_vsync,
  input  logic                    in_de,
  input  logic                    in_frame,
  input  logic [BPC-1:0]          in_r,
  input  logic [BPC-1:0]          in_g,
  input  logic [BPC-1:0]          in_b,
  input  logic [1:0]              mode,
  output logic signed [CORDW-1:0] out_x,
  output logic signed [CORDW-1:0] out_y,
  output logic                    out_hsync,
  output logic                    out_vsync,
  output logic                    out_de,
  output logic                    out_frame,
  output logic [BPC_BOARD-1:0]    out_r,
  output logic [BPC_BOARD-1:0]    out_g,
  output logic [BPC_BOARD-1:0]    out_b,
  output logic [1:0]              mode_active,
  output logic [15:0]             frame_count
);

  // Width of one colour bar and of the in-bar pixel counter. The +1 keeps
  // the counter at least one bit wide even for a one-pixel bar.
  localparam int BAR_W = H_RES / 8;
  localparam int PCW   = $clog2(BAR_W + 1);

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_GREY  = 2'd1,
    MODE_BARS  = 2'd2,
    MODE_BLANK = 2'd3
  } mode_e;

  // One pipeline word: everything that must stay aligned with the colour.
  typedef struct packed {
    logic [CORDW-1:0]     x;
    logic [CORDW-1:0]     y;
    logic                 hsync;
    logic                 vsync;
    logic                 de;
    logic                 frame;
    logic [BPC_BOARD-1:0] r;
    logic [BPC_BOARD-1:0] g;
    logic [BPC_BOARD-1:0] b;
  } pkt_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  mode_e          mode_active_q, mode_active_d;
  logic [15:0]    frame_count_q, frame_count_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic [2:0]     bar_q, bar_d;
  pkt_t           stage_q [PIPE];
  pkt_t           stage_d [PIPE];

  // ---------------------------------------------------------------------------
  // Stage-1 combinational processing
  // ---------------------------------------------------------------------------
  mode_e          eff_mode;
  logic [BPC+1:0] grey_sum;
  logic [BPC-1:0] grey;
  logic [2:0]     bar_rgb;
  logic [BPC-1:0] col_r, col_g, col_b;
  logic [BPC_BOARD-1:0] exp_r, exp_g, exp_b;
  pkt_t           pix_d;

  always_comb begin
    // On the in_frame cycle the requested mode already applies, so the first
    // pixel of a frame is drawn in the new mode.
    eff_mode      = in_frame ? mode_e'(mode) : mode_active_q;
    mode_active_d = eff_mode;

    // Wraps naturally at 16 bits.
    frame_count_d = frame_count_q + {15'd0, in_frame};

    // r + 2g + b fits in BPC+2 bits; dividing by four brings it back to BPC.
    grey_sum = {2'b00, in_r} + {1'b0, in_g, 1'b0} + {2'b00, in_b};
    grey     = BPC'(grey_sum >> 2);

    // Bar i shows colour 7-i with each {r,g,b} bit driving a full channel.
    bar_rgb = 3'd7 - bar_q;

    col_r = '0;
    col_g = '0;
    col_b = '0;
    unique case (eff_mode)
      MODE_PASS: begin
        col_r = in_r;
        col_g = in_g;
        col_b = in_b;
      end
      MODE_GREY: begin
        col_r = grey;
        col_g = grey;
        col_b = grey;
      end
      MODE_BARS: begin
        col_r = {BPC{bar_rgb[2]}};
        col_g = {BPC{bar_rgb[1]}};
        col_b = {BPC{bar_rgb[0]}};
      end
      MODE_BLANK: begin
        col_r = '0;
        col_g = '0;
        col_b = '0;
      end
      default: begin
        col_r = '0;
        col_g = '0;
        col_b = '0;
      end
    endcase

    // Nothing but black may leave the block outside the active area.
    if (!in_de) begin
      col_r = '0;
      col_g = '0;
      col_b = '0;
    end
  end

  // Bar position tracking. The counters follow data-enable only, so bars are
  // independent of the coordinate inputs and restart on every line.
  always_comb begin
    pc_d  = pc_q;
    bar_d = bar_q;
    if (!in_de) begin
      pc_d  = '0;
      bar_d = '0;
    end else if (pc_q == PCW'(BAR_W - 1)) begin
      pc_d  = '0;
      bar_d = (bar_q == 3'd7) ? 3'd7 : bar_q + 3'd1;
    end else begin
      pc_d = pc_q + PCW'(1);
    end
  end

  // Colour expansion: output bit k (counted from the MSB) takes input bit
  // (k mod BPC) counted from the MSB, i.e. the input word repeated MSB-first
  // and cut to BPC_BOARD bits. All-ones and zero therefore map exactly.
  genvar gi;
  generate
    for (gi = 0; gi < BPC_BOARD; gi++) begin : g_expand
      assign exp_r[BPC_BOARD-1-gi] = col_r[BPC-1-(gi % BPC)];
      assign exp_g[BPC_BOARD-1-gi] = col_g[BPC-1-(gi % BPC)];
      assign exp_b[BPC_BOARD-1-gi] = col_b[BPC-1-(gi % BPC)];
    end
  endgenerate

  always_comb begin
    pix_d       = '0;
    pix_d.x     = in_x;
    pix_d.y     = in_y;
    pix_d.hsync = in_hsync;
    pix_d.vsync = in_vsync;
    pix_d.de    = in_de;
    pix_d.frame = in_frame;
    pix_d.r     = exp_r;
    pix_d.g     = exp_g;
    pix_d.b     = exp_b;
  end

  // Stage 0 takes the processed word, later stages are pure delay.
  always_comb begin
    stage_d[0] = pix_d;
    for (int k = 1; k < PIPE; k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_active_q <= MODE_PASS;
      frame_count_q <= '0;
      pc_q          <= '0;
      bar_q         <= '0;
    end else begin
      mode_active_q <= mode_active_d;
      frame_count_q <= frame_count_d;
      pc_q          <= pc_d;
      bar_q         <= bar_d;
    end
  end

  // Clearing every stage on reset discards any half-drawn line, so no stale
  // pixels appear after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < PIPE; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < PIPE; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_x       = stage_q[PIPE-1].x;
  assign out_y       = stage_q[PIPE-1].y;
  assign out_hsync   = stage_q[PIPE-1].hsync;
  assign out_vsync   = stage_q[PIPE-1].vsync;
  assign out_de      = stage_q[PIPE-1].de;
  assign out_frame   = stage_q[PIPE-1].frame;
  assign out_r       = stage_q[PIPE-1].r;
  assign out_g       = stage_q[PIPE-1].g;
  assign out_b       = stage_q[PIPE-1].b;
  assign mode_active = mode_active_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_disp_out_pipe.sv
// -----------------------------------------------------------------------------
// tb_disp_out_pipe
//
// Self-checking bench for disp_out_pipe. The main instance uses the default
// 5->8 bit configuration with PIPE=2; two extra 8->8 bit instances (PIPE=1
// and PIPE=8, mode tied to pass) share the timing inputs for the latency
// sweep. Expected values come from a behavioural model of the display rules.
// -----------------------------------------------------------------------------
module tb_disp_out_pipe;

  localparam int CORDW = 16;
  localparam int PIPE  = 2;
  localparam int H_RES = 640;
  localparam int BAR_W = H_RES / 8;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        hs;
    logic        vs;
    logic        de;
    logic        fr;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
  } pkt_t;

  logic clk;
  logic rst_n;
  logic signed [CORDW-1:0] in_x, in_y;
  logic in_hsync, in_vsync, in_de, in_frame;
  logic [4:0] in_r, in_g, in_b;
  logic [1:0] mode;

  logic signed [CORDW-1:0] out_x, out_y;
  logic out_hsync, out_vsync, out_de, out_frame;
  logic [7:0] out_r, out_g, out_b;
  logic [1:0] mode_active;
  logic [15:0] frame_count;

  logic [7:0] s_r, s_g, s_b;
  logic signed [CORDW-1:0] p1_x, p1_y, p8_x, p8_y;
  logic p1_hs, p1_vs, p1_de, p1_fr, p8_hs, p8_vs, p8_de, p8_fr;
  logic [7:0] p1_r, p1_g, p1_b, p8_r, p8_g, p8_b;
  logic [1:0] p1_mode, p8_mode;
  logic [15:0] p1_fc, p8_fc;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model state
  logic [1:0]  m_mode;
  logic [15:0] m_fc;
  int          m_run;
  pkt_t        m_q[$];
  pkt_t        exp_pkt;

  disp_out_pipe #(.BPC(5), .BPC_BOARD(8), .CORDW(CORDW), .PIPE(PIPE), .H_RES(H_RES)) dut (
    .clk(clk), .rst_n(rst_n), .in_x(in_x), .in_y(in_y),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_de(in_de), .in_frame(in_frame),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .mode(mode),
    .out_x(out_x), .out_y(out_y), .out_hsync(out_hsync), .out_vsync(out_vsync),
    .out_de(out_de), .out_frame(out_frame), .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .mode_active(mode_active), .frame_count(frame_count)
  );

  disp_out_pipe #(.BPC(8), .BPC_BOARD(8), .CORDW(CORDW), .PIPE(1), .H_RES(H_RES)) dut_p1 (
    .clk(clk), .rst_n(rst_n), .in_x(in_x), .in_y(in_y),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_de(in_de), .in_frame(in_frame),
    .in_r(s_r), .in_g(s_g), .in_b(s_b), .mode(2'b00),
    .out_x(p1_x), .out_y(p1_y), .out_hsync(p1_hs), .out_vsync(p1_vs),
    .out_de(p1_de), .out_frame(p1_fr), .out_r(p1_r), .out_g(p1_g), .out_b(p1_b),
    .mode_active(p1_mode), .frame_count(p1_fc)
  );

  disp_out_pipe #(.BPC(8), .BPC_BOARD(8), .CORDW(CORDW), .PIPE(8), .H_RES(H_RES)) dut_p8 (
    .clk(clk), .rst_n(rst_n), .in_x(in_x), .in_y(in_y),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_de(in_de), .in_frame(in_frame),
    .in_r(s_r), .in_g(s_g), .in_b(s_b), .mode(2'b00),
    .out_x(p8_x), .out_y(p8_y), .out_hsync(p8_hs), .out_vsync(p8_vs),
    .out_de(p8_de), .out_frame(p8_fr), .out_r(p8_r), .out_g(p8_g), .out_b(p8_b),
    .mode_active(p8_mode), .frame_count(p8_fc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 5-bit value repeated MSB-first as an integer and trimmed to 8 bits.
  function automatic logic [7:0] expand(input logic [4:0] c);
    int v;
    int bits;
    v    = int'(c);
    bits = 5;
    while (bits < 8) begin
      v    = (v << 5) | int'(c);
      bits = bits + 5;
    end
    return 8'(v >> (bits - 8));
  endfunction

  function automatic pkt_t dut_pkt();
    return {out_x, out_y, out_hsync, out_vsync, out_de, out_frame, out_r, out_g, out_b};
  endfunction

  task automatic model_reset();
    pkt_t z;
    z = '0;
    m_q.delete();
    for (int k = 0; k < PIPE - 1; k++) m_q.push_back(z);
    m_mode = 2'd0;
    m_fc   = 16'd0;
    m_run  = 0;
  endtask

  // Feed the current inputs to the model, advance one clock, and leave the
  // packet that should now be on the outputs in exp_pkt.
  task automatic step();
    pkt_t       p;
    logic [1:0] eff;
    logic [4:0] cr, cg, cb;
    int         gsum, bi, rgb;
    eff = in_frame ? mode : m_mode;
    cr = 5'd0; cg = 5'd0; cb = 5'd0;
    case (eff)
      2'd0: begin cr = in_r; cg = in_g; cb = in_b; end
      2'd1: begin
        gsum = int'(in_r) + 2 * int'(in_g) + int'(in_b);
        cr = 5'(gsum / 4); cg = cr; cb = cr;
      end
      2'd2: begin
        bi = m_run / BAR_W;
        if (bi > 7) bi = 7;
        rgb = 7 - bi;
        cr = ((rgb >> 2) & 1) != 0 ? 5'h1F : 5'h00;
        cg = ((rgb >> 1) & 1) != 0 ? 5'h1F : 5'h00;
        cb = (rgb & 1) != 0 ? 5'h1F : 5'h00;
      end
      default: begin cr = 5'd0; cg = 5'd0; cb = 5'd0; end
    endcase
    if (!in_de) begin cr = 5'd0; cg = 5'd0; cb = 5'd0; end
    p = {in_x, in_y, in_hsync, in_vsync, in_de, in_frame, expand(cr), expand(cg), expand(cb)};
    m_q.push_back(p);
    if (in_frame) begin
      m_mode = mode;
      m_fc   = m_fc + 16'd1;
    end
    m_run = in_de ? m_run + 1 : 0;
    @(posedge clk);
    #1;
    exp_pkt = m_q.pop_front();
    cyc++;
  endtask

  task automatic idle_inputs();
    in_x = '0; in_y = '0; in_hsync = 0; in_vsync = 0; in_de = 0; in_frame = 0;
    in_r = '0; in_g = '0; in_b = '0; mode = 2'd0;
    s_r = '0; s_g = '0; s_b = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic rand_colour();
    in_r = 5'($urandom); in_g = 5'($urandom); in_b = 5'($urandom);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (dut_pkt() !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", dut_pkt());
    end
    total++;
    if (mode_active !== 2'd0 || frame_count !== 16'd0) begin
      bad++; $display("FAIL reset_state got mode=%0d fc=%0d want mode=0 fc=0", mode_active, frame_count);
    end
    @(negedge clk); @(negedge clk);
    total++;
    if (dut_pkt() !== '0) begin
      bad++; $display("FAIL reset_held got=%h want=0", dut_pkt());
    end
    rst_n = 1'b1;
    model_reset();
    $display("[tb] test_reset done t=%0t", $time);
  endtask

  task automatic test_pass();
    logic [15:0] sx, sy;
    mode = 2'd0; in_frame = 1'b1; in_de = 1'b0;
    step();
    in_frame = 1'b0;
    sx = 16'($urandom); sy = 16'($urandom);
    in_x = sx; in_y = sy; in_hsync = 1'b1; in_vsync = 1'b0; in_de = 1'b1;
    in_r = 5'h1F; in_g = 5'h10; in_b = 5'h00;
    step();
    in_de = 1'b0; in_hsync = 1'b0; in_vsync = 1'b1; in_r = '0; in_g = '0;
    step();
    total++;
    if (out_r !== 8'hFF || out_g !== 8'h84 || out_b !== 8'h00) begin
      bad++; $display("FAIL pass_colour got=%h/%h/%h want=ff/84/00", out_r, out_g, out_b);
    end
    total++;
    if (out_x !== sx || out_y !== sy || out_de !== 1'b1 || out_hsync !== 1'b1 || out_vsync !== 1'b0 || out_frame !== 1'b0) begin
      bad++; $display("FAIL pass_timing got x=%h y=%h de=%b hs=%b vs=%b fr=%b want x=%h y=%h de=1 hs=1 vs=0 fr=0",
                      out_x, out_y, out_de, out_hsync, out_vsync, out_frame, sx, sy);
    end
    for (int c = 0; c < 200; c++) begin
      in_x = 16'($urandom); in_y = 16'($urandom); in_hsync = 1'($urandom); in_vsync = 1'($urandom);
      in_de = ($urandom_range(0, 3) != 0); rand_colour();
      step();
      total++;
      if (dut_pkt() !== exp_pkt) begin
        bad++; $display("FAIL pass_pkt cyc=%0d got=%h want=%h", cyc, dut_pkt(), exp_pkt);
      end
    end
    $display("[tb] test_pass done t=%0t", $time);
  endtask

  task automatic test_grey();
    mode = 2'd1; in_frame = 1'b1; in_de = 1'b1;
    in_r = 5'h1F; in_g = 5'h1F; in_b = 5'h00;
    step();
    in_frame = 1'b0; in_de = 1'b0;
    step();
    total++;
    if (out_r !== 8'hBD || out_g !== 8'hBD || out_b !== 8'hBD) begin
      bad++; $display("FAIL grey_first_pixel got=%h/%h/%h want=bd/bd/bd", out_r, out_g, out_b);
    end
    total++;
    if (mode_active !== 2'd1) begin
      bad++; $display("FAIL grey_mode_active got=%0d want=1", mode_active);
    end
    step();
    total++;
    if (out_r !== 8'h00 || out_g !== 8'h00 || out_b !== 8'h00 || out_de !== 1'b0) begin
      bad++; $display("FAIL grey_blanked got=%h/%h/%h de=%b want=0/0/0 de=0", out_r, out_g, out_b, out_de);
    end
    for (int c = 0; c < 200; c++) begin
      in_de = ($urandom_range(0, 3) != 0); rand_colour();
      in_x = 16'(c);
      step();
      total++;
      if (dut_pkt() !== exp_pkt) begin
        bad++; $display("FAIL grey_pkt cyc=%0d got=%h want=%h", cyc, dut_pkt(), exp_pkt);
      end
    end
    $display("[tb] test_grey done t=%0t", $time);
  endtask

  task automatic test_bars();
    int len, bi, rgb;
    logic [7:0] er, eg, eb;
    apply_reset();
    mode = 2'd2; in_frame = 1'b0; in_de = 1'b1;
    for (int c = 0; c < 5; c++) begin
      rand_colour();
      step();
      total++;
      if (mode_active !== 2'd0) begin
        bad++; $display("FAIL bars_no_early_switch got=%0d want=0", mode_active);
      end
    end
    in_frame = 1'b1; in_de = 1'b0;
    step();
    total++;
    if (mode_active !== 2'd2) begin
      bad++; $display("FAIL bars_switch got=%0d want=2", mode_active);
    end
    in_frame = 1'b0;
    for (int line = 0; line < 2; line++) begin
      len = (line == 0) ? H_RES : 100;
      for (int p = -4; p < len + 4; p++) begin
        in_de = (p >= 0 && p < len);
        in_x  = 16'(p);
        in_y  = 16'(line);
        rand_colour();
        step();
        total++;
        if (dut_pkt() !== exp_pkt) begin
          bad++; $display("FAIL bars_pkt cyc=%0d got=%h want=%h", cyc, dut_pkt(), exp_pkt);
        end
        if (exp_pkt.de) begin
          bi  = int'(exp_pkt.x) / BAR_W;
          rgb = 7 - bi;
          er = ((rgb >> 2) & 1) != 0 ? 8'hFF : 8'h00;
          eg = ((rgb >> 1) & 1) != 0 ? 8'hFF : 8'h00;
          eb = (rgb & 1) != 0 ? 8'hFF : 8'h00;
          total++;
          if (out_r !== er || out_g !== eg || out_b !== eb) begin
            bad++; $display("FAIL bars_colour line=%0d px=%0d got=%h/%h/%h want=%h/%h/%h",
                            line, exp_pkt.x, out_r, out_g, out_b, er, eg, eb);
          end
        end
      end
    end
    $display("[tb] test_bars done t=%0t", $time);
  endtask

  task automatic test_random();
    int pos;
    apply_reset();
    for (int c = 0; c < 2880; c++) begin
      pos = c % 720;
      in_de     = (pos < 640);
      in_x      = 16'(pos);
      in_y      = 16'(c / 720);
      in_hsync  = (pos >= 656 && pos < 700);
      in_vsync  = ($urandom_range(0, 7) == 0);
      in_frame  = (pos == 710) || ($urandom_range(0, 299) == 0);
      mode      = 2'($urandom);
      rand_colour();
      step();
      total++;
      if (dut_pkt() !== exp_pkt) begin
        bad++; $display("FAIL random_pkt cyc=%0d got=%h want=%h", cyc, dut_pkt(), exp_pkt);
      end
      total++;
      if (mode_active !== m_mode || frame_count !== m_fc) begin
        bad++; $display("FAIL random_state cyc=%0d got mode=%0d fc=%0d want mode=%0d fc=%0d",
                        cyc, mode_active, frame_count, m_mode, m_fc);
      end
    end
    $display("[tb] test_random done t=%0t", $time);
  endtask

  task automatic test_frame_wrap();
    apply_reset();
    in_frame = 1'b1; in_de = 1'b0;
    for (int c = 0; c < 65537; c++) step();
    total++;
    if (frame_count !== 16'h0001 || frame_count !== m_fc) begin
      bad++; $display("FAIL frame_wrap got=%h want=0001", frame_count);
    end
    in_de = 1'b1; mode = 2'd3; rand_colour();
    step();
    total++;
    if (frame_count !== 16'h0002) begin
      bad++; $display("FAIL frame_with_de got=%h want=0002", frame_count);
    end
    in_frame = 1'b0; in_de = 1'b0;
    step();
    total++;
    if (dut_pkt() !== exp_pkt || out_r !== 8'h00 || out_frame !== 1'b1) begin
      bad++; $display("FAIL frame_de_pixel got=%h want=%h", dut_pkt(), exp_pkt);
    end
    $display("[tb] test_frame_wrap done t=%0t", $time);
  endtask

  task automatic test_async_reset();
    apply_reset();
    mode = 2'd1; in_frame = 1'b1; in_de = 1'b0;
    step();
    in_frame = 1'b0;
    for (int c = 0; c < 20; c++) begin
      in_de = 1'b1; in_x = 16'(c); rand_colour();
      step();
      total++;
      if (dut_pkt() !== exp_pkt) begin
        bad++; $display("FAIL areset_pre cyc=%0d got=%h want=%h", cyc, dut_pkt(), exp_pkt);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (dut_pkt() !== '0 || mode_active !== 2'd0 || frame_count !== 16'd0) begin
      bad++; $display("FAIL areset_immediate got=%h mode=%0d fc=%0d want all 0", dut_pkt(), mode_active, frame_count);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < PIPE + 4; k++) begin
      in_de = 1'b1; in_x = 16'(100 + k); rand_colour();
      step();
      if (k < PIPE - 1) begin
        total++;
        if (out_de !== 1'b0) begin
          bad++; $display("FAIL areset_de_hold k=%0d got=%b want=0", k, out_de);
        end
      end
      total++;
      if (dut_pkt() !== exp_pkt || mode_active !== 2'd0) begin
        bad++; $display("FAIL areset_post k=%0d got=%h mode=%0d want=%h mode=0", k, dut_pkt(), mode_active, exp_pkt);
      end
    end
    $display("[tb] test_async_reset done t=%0t", $time);
  endtask

  task automatic test_pipe_sweep();
    pkt_t hist[100];
    pkt_t e1, e8, g1, g8;
    apply_reset();
    mode = 2'd0;
    for (int t = 0; t < 100; t++) begin
      in_x = 16'($urandom); in_y = 16'($urandom);
      in_hsync = 1'($urandom); in_vsync = 1'($urandom);
      in_de = ($urandom_range(0, 4) != 0); in_frame = ($urandom_range(0, 9) == 0);
      s_r = 8'($urandom); s_g = 8'($urandom); s_b = 8'($urandom);
      rand_colour();
      hist[t] = {in_x, in_y, in_hsync, in_vsync, in_de, in_frame,
                 in_de ? s_r : 8'h00, in_de ? s_g : 8'h00, in_de ? s_b : 8'h00};
      step();
      e1 = hist[t];
      e8 = (t >= 7) ? hist[t-7] : '0;
      g1 = {p1_x, p1_y, p1_hs, p1_vs, p1_de, p1_fr, p1_r, p1_g, p1_b};
      g8 = {p8_x, p8_y, p8_hs, p8_vs, p8_de, p8_fr, p8_r, p8_g, p8_b};
      total++;
      if (g1 !== e1) begin
        bad++; $display("FAIL sweep_pipe1 t=%0d got=%h want=%h", t, g1, e1);
      end
      total++;
      if (g8 !== e8) begin
        bad++; $display("FAIL sweep_pipe8 t=%0d got=%h want=%h", t, g8, e8);
      end
    end
    $display("[tb] test_pipe_sweep done t=%0t", $time);
  endtask

  initial begin
    test_reset();
    test_pass();
    test_grey();
    test_bars();
    test_random();
    test_frame_wrap();
    test_async_reset();
    test_pipe_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
